scc_control_sequencer: RTL
==========================

Name: scc_control_sequencer

Overview:
- Multi-cycle control FSM for the SCC core.
- Sequences fetch, decode, execute, memory and writeback for each instruction, using the decoded fields from the instruction-decode stage.
- Drives the PC, IR, register-file, flag-register and data-memory enables.
- Tracks retired instructions and flags memory-handshake timeouts.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- TIMEOUT, 64: maximum wait cycles on imem_ready or mem_ready before a fault.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- first_ld  in  2  instruction class: 00 data-imm, 01 data-reg, 10 load/store, 11 system/branch.
- special_enc  in  1  ALU-op encoding flag.
- second_ld  in  4  instr[28:25]; second_ld[0] = store select for class 10.
- b_cond  in  4  branch condition mask.
- flags  in  4  current NZCV flags.
- imem_ready  in  1  instruction memory returns data this cycle.
- mem_ready  in  1  data memory completes access this cycle.
- state  out  3  current state encoding.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  latch the instruction register.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC := branch target.
- alu_en  out  1  ALU operates.
- reg_we  out  1  register-file write.
- flag_we  out  1  flag-register write.
- wb_sel_mem  out  1  writeback source: 1 = memory, 0 = ALU.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write.
- halted  out  1  core halted.
- fault  out  1  handshake timeout occurred.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6.
- Reset (asynchronous, any state, including mid-MEM): state=FETCH, retired=0, wait counter=0. All strobes deassert immediately.
- Strobes are a combinational decode of state and inputs. Strobes not listed for a state are 0.
- Decoded inputs must be stable from the cycle after ir_load until the next FETCH.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_load=1 and pc_inc=1 that cycle; next state DECODE.
  - Otherwise the wait counter increments. Reaching TIMEOUT goes to FAULT.
- DECODE (1 cycle): classify the instruction.
  - Class 11, second_ld[2]=1 → NOP: retire, go to FETCH.
  - Class 11, second_ld[3]=1 and second_ld[2]=0 → HALT (not retired).
  - Class 11, second_ld=0011 → NOP.
  - All other encodings → EXEC.
- EXEC:
  - Class 00/01: alu_en=1; next state WB.
  - Class 10: alu_en=1 (address = base + offset); next state MEM; wait counter cleared.
  - Branch 0000 (B): pc_load=1.
  - Branch 0001 (Bcond): pc_load = |(b_cond & flags).
  - Branch 0010 (BR): pc_load=1.
  - Branches retire and go to FETCH.
- MEM:
  - mem_req=1; mem_we=second_ld[0].
  - Load completes on mem_ready=1 → WB.
  - Store completes on mem_ready=1 → retire, go to FETCH.
  - The wait counter counts cycles without mem_ready. Reaching TIMEOUT → FAULT.
- WB (1 cycle):
  - reg_we=1.
  - wb_sel_mem=1 for class 10.
  - flag_we = special_enc & second_ld[3] & (first_ld==00 or 01). These are the "s" variants.
  - Retire; go to FETCH.
- Retire: retired increments by 1 on the retiring cycle. It wraps modulo 2^CNT_W.
- HALT: halted=1; held until reset.
- FAULT: fault=1, halted=1; held until reset.
- Wait counter: cleared on entering FETCH or MEM, and on every ready.
- Latency:
  - ALU op: 4 cycles (F, D, E, WB) with zero memory waits.
  - Load: 5 + memory waits.
  - Store: 4 + memory waits.
  - Branch: 3.
  - NOP: 2.
- Ready seen in a state that does not request it: ignored.

Test Plan:
- ADDS imm (first_ld=00, special=1, second_ld=1001), imem_ready=1 → states 0,1,2,4. flag_we=1 and reg_we=1 in WB; retired=1.
- Load (first_ld=10, second_ld[0]=0), mem_ready after 3 cycles → MEM held 4 cycles with mem_we=0. WB has wb_sel_mem=1, reg_we=1.
- Bcond b_cond=0100, flags=0100 → pc_load=1 in EXEC. Repeat with flags=0000 → pc_load=0. Both retire.
- HALT (first_ld=11, second_ld=1000) → halted=1 held, retired unchanged. Pulse rst → state=FETCH, halted=0.
- Store with mem_ready held 0 → after TIMEOUT=64 cycles state=FAULT, fault=1. Assert rst mid-MEM in a separate run → FETCH immediately, mem_req=0.
- CNT_W=4: retire 16 NOPs → retired wraps to 0.

Source files
------------

// File: rtl/scc_control_sequencer.sv
// Multi-cycle control sequencer for the SCC core: fetch/decode/execute/memory/writeback
// strobes, retired-instruction counter and handshake-timeout fault detection.
module scc_control_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       first_ld,
  input  logic             special_enc,
  input  logic [3:0]       second_ld,
  input  logic [3:0]       b_cond,
  input  logic [3:0]       flags,
  input  logic             imem_ready,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             alu_en,
  output logic             reg_we,
  output logic             flag_we,
  output logic             wb_sel_mem,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(TIMEOUT);

  localparam logic [1:0] ClsMem = 2'b10;
  localparam logic [1:0] ClsSys = 2'b11;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StFault  = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             is_sys, is_mem, is_alu;
  logic             dec_nop, dec_halt;
  logic             br_take;
  logic             timed_out;

  assign is_sys = (first_ld == ClsSys);
  assign is_mem = (first_ld == ClsMem);
  assign is_alu = ~first_ld[1];

  // Class 11 encodings not caught here are branches (0000, 0001, 0010).
  assign dec_nop  = is_sys & (second_ld[2] | (second_ld == 4'b0011));
  assign dec_halt = is_sys & second_ld[3] & ~second_ld[2];

  assign wait_inc  = wait_q + WaitW'(1);
  assign timed_out = (wait_inc == WaitLimit);

  always_comb begin
    br_take = 1'b0;
    case (second_ld)
      4'b0000, 4'b0010: br_take = 1'b1;
      4'b0001:          br_take = |(b_cond & flags);
      default:          br_take = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    flag_we    = 1'b0;
    wb_sel_mem = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          wait_d  = '0;
          state_d = StDecode;
        end else begin
          wait_d = wait_inc;
          if (timed_out) state_d = StFault;
        end
      end

      StDecode: begin
        if (dec_nop) begin
          retire  = 1'b1;
          wait_d  = '0;
          state_d = StFetch;
        end else if (dec_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        if (is_sys) begin
          pc_load = br_take;
          retire  = 1'b1;
          wait_d  = '0;
          state_d = StFetch;
        end else if (is_mem) begin
          // ALU forms the effective address for the memory access.
          alu_en  = 1'b1;
          wait_d  = '0;
          state_d = StMem;
        end else begin
          alu_en  = 1'b1;
          state_d = StWb;
        end
      end

      StMem: begin
        mem_req = 1'b1;
        mem_we  = second_ld[0];
        if (mem_ready) begin
          wait_d = '0;
          if (second_ld[0]) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else begin
          wait_d = wait_inc;
          if (timed_out) state_d = StFault;
        end
      end

      StWb: begin
        reg_we     = 1'b1;
        wb_sel_mem = is_mem;
        flag_we    = special_enc & second_ld[3] & is_alu;
        retire     = 1'b1;
        wait_d     = '0;
        state_d    = StFetch;
      end

      StHalt: begin
        halted = 1'b1;
      end

      StFault: begin
        fault  = 1'b1;
        halted = 1'b1;
      end

      default: begin
        state_d = StFault;
      end
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
